// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, drives the cache
//               instruction port and buffers fetched words for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int ADDR_W   = 64,
    parameter int INSTR_W  = 32,
    parameter int FQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  entry,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               icache_read,
    output logic [ADDR_W-1:0]  icache_addr,
    input  logic               icache_busy,
    input  logic [INSTR_W-1:0] icache_data,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    input  logic               id_ready
);

    localparam int c_PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FQ_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W-1:0]    target_q, target_d;
    logic [c_PTR_W-1:0]   head_q, head_d;
    logic [c_PTR_W-1:0]   tail_q, tail_d;
    logic [c_CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]    fq_pc_q    [FQ_DEPTH];
    logic [INSTR_W-1:0]   fq_instr_q [FQ_DEPTH];

    logic                 w_complete;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic [ADDR_W-1:0]    w_redir_pc;

    assign icache_read = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign icache_addr = pc_q;
    assign if_valid    = (count_q != '0);
    assign if_pc       = fq_pc_q[head_q];
    assign if_instr    = fq_instr_q[head_q];

    assign w_redir_pc  = redirect_pc & ~ADDR_W'(3);
    assign w_complete  = icache_read && !icache_busy;
    assign w_full      = (count_q == c_FULL);
    // A redirect cancels any same-cycle push or pop; words completing in DRAIN are never queued.
    assign w_pop       = if_valid && id_ready && !redirect_valid;
    assign w_push      = (state_q == ST_FETCH) && w_complete && !redirect_valid
                         && (!w_full || w_pop);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        if (redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_push) tail_d = tail_q + c_PTR_W'(1);
            if (w_pop)  head_d = head_q + c_PTR_W'(1);
            count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (redirect_valid) pc_d = w_redir_pc;
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    if (icache_busy) begin
                        // Request in flight: address must hold until it completes.
                        target_d = w_redir_pc;
                        state_d  = ST_DRAIN;
                    end else begin
                        pc_d = w_redir_pc;
                    end
                end else if (w_push) begin
                    pc_d = pc_q + ADDR_W'(4);
                    if (count_d == c_FULL) state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (redirect_valid) begin
                    pc_d    = w_redir_pc;
                    state_d = ST_FETCH;
                end else if (!w_full || w_pop) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) target_d = w_redir_pc;
                if (!icache_busy) begin
                    pc_d    = redirect_valid ? w_redir_pc : target_q;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= entry;
            target_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_pc_q[i]    <= '0;
                fq_instr_q[i] <= '0;
            end
        end else if (w_push) begin
            fq_pc_q[tail_q]    <= pc_q;
            fq_instr_q[tail_q] <= icache_data;
        end
    end

endmodule
`default_nettype wire
